// File: rtl/axi_remap_ctrl.sv
// axi_remap_ctrl: supplies the upper address bits (cur_base) for the AXI
// address mapper. It can change the base at run time. Before the switch it
// closes the AR/AW channels and waits for every outstanding read and write
// to finish. It also gates the AR/AW handshakes and counts outstanding
// transactions on each channel.
module axi_remap_ctrl #(
  parameter int unsigned       BASE_W     = 4,
  parameter logic [BASE_W-1:0] RESET_BASE = 'h8,
  parameter int unsigned       MAX_OUTST  = 16,
  localparam int unsigned      CW         = $clog2(MAX_OUTST + 1)
) (
  input  logic              clk,
  input  logic              reset,
  // Base-change request
  input  logic              cfg_valid,
  input  logic [BASE_W-1:0] cfg_base,
  output logic              cfg_ready,
  output logic [BASE_W-1:0] cur_base,
  output logic              busy,
  output logic              err_underflow,
  // AR gating
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic              m_arvalid,
  input  logic              m_arready,
  // AW gating
  input  logic              s_awvalid,
  output logic              s_awready,
  output logic              m_awvalid,
  input  logic              m_awready,
  // Completion observation
  input  logic              m_rvalid,
  input  logic              m_rready,
  input  logic              m_rlast,
  input  logic              m_bvalid,
  input  logic              m_bready,
  output logic [CW-1:0]     ar_outst,
  output logic [CW-1:0]     aw_outst
);

  localparam logic [CW-1:0] MaxCnt = CW'(MAX_OUTST);
  localparam logic [CW-1:0] OneCnt = CW'(1);

  typedef enum logic [1:0] {StRun, StDrain, StSwitch} state_e;

  state_e            state_q;
  logic [BASE_W-1:0] new_base_q;
  logic [BASE_W-1:0] cur_base_q;
  logic [CW-1:0]     ar_cnt_q, ar_cnt_d;
  logic [CW-1:0]     aw_cnt_q, aw_cnt_d;
  logic              ar_hold_q, ar_hold_d;
  logic              aw_hold_q, aw_hold_d;
  logic              err_q;
  logic              ar_uflow, aw_uflow;
  logic              ar_open, aw_open;
  logic              ar_fire, aw_fire;
  logic              r_done, b_done;
  logic              drained;

  // A channel is open in RUN below the limit. A valid that is already exposed
  // downstream stays open in any state, so it is never withdrawn.
  assign ar_open = ((state_q == StRun) && (ar_cnt_q < MaxCnt)) || ar_hold_q;
  assign aw_open = ((state_q == StRun) && (aw_cnt_q < MaxCnt)) || aw_hold_q;

  assign m_arvalid = s_arvalid && ar_open;
  assign s_arready = m_arready && ar_open;
  assign m_awvalid = s_awvalid && aw_open;
  assign s_awready = m_awready && aw_open;

  assign ar_fire = m_arvalid && m_arready;
  assign aw_fire = m_awvalid && m_awready;
  assign r_done  = m_rvalid && m_rready && m_rlast;
  assign b_done  = m_bvalid && m_bready;

  assign drained = (ar_cnt_q == '0) && (aw_cnt_q == '0) && !ar_hold_q && !aw_hold_q;

  assign cfg_ready     = (state_q == StSwitch);
  assign busy          = (state_q != StRun);
  assign cur_base      = cur_base_q;
  assign err_underflow = err_q;
  assign ar_outst      = ar_cnt_q;
  assign aw_outst      = aw_cnt_q;

  // AR counter next state: a fire and a completion in the same cycle cancel out.
  always_comb begin
    ar_cnt_d = ar_cnt_q;
    ar_uflow = 1'b0;
    if (ar_fire && !r_done) begin
      if (ar_cnt_q != MaxCnt) ar_cnt_d = ar_cnt_q + OneCnt;
    end else if (r_done && !ar_fire) begin
      if (ar_cnt_q == '0) ar_uflow = 1'b1;
      else                ar_cnt_d = ar_cnt_q - OneCnt;
    end
  end

  // AW counter next state, same rules as AR with B as the completion.
  always_comb begin
    aw_cnt_d = aw_cnt_q;
    aw_uflow = 1'b0;
    if (aw_fire && !b_done) begin
      if (aw_cnt_q != MaxCnt) aw_cnt_d = aw_cnt_q + OneCnt;
    end else if (b_done && !aw_fire) begin
      if (aw_cnt_q == '0) aw_uflow = 1'b1;
      else                aw_cnt_d = aw_cnt_q - OneCnt;
    end
  end

  // Hold tracking: set while a downstream valid waits for ready.
  always_comb begin
    ar_hold_d = ar_hold_q;
    aw_hold_d = aw_hold_q;
    if (m_arvalid) ar_hold_d = !m_arready;
    if (m_awvalid) aw_hold_d = !m_awready;
  end

  // Outstanding counters, hold flags and the sticky underflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ar_cnt_q  <= '0;
      aw_cnt_q  <= '0;
      ar_hold_q <= 1'b0;
      aw_hold_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ar_cnt_q  <= ar_cnt_d;
      aw_cnt_q  <= aw_cnt_d;
      ar_hold_q <= ar_hold_d;
      aw_hold_q <= aw_hold_d;
      if (ar_uflow || aw_uflow) err_q <= 1'b1;
    end
  end

  // Remap FSM. The base changes only on the SWITCH->RUN edge, after the drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StRun;
      new_base_q <= RESET_BASE;
      cur_base_q <= RESET_BASE;
    end else begin
      unique case (state_q)
        StRun: begin
          if (cfg_valid) begin
            new_base_q <= cfg_base;
            state_q    <= StDrain;
          end
        end
        StDrain: begin
          if (drained) state_q <= StSwitch;
        end
        StSwitch: begin
          cur_base_q <= new_base_q;
          state_q    <= StRun;
        end
        default: state_q <= StRun;
      endcase
    end
  end

  // The limit is a hard ceiling. A held address always sits below it.
  a_ar_limit : assert property (@(posedge clk) disable iff (reset) ar_cnt_q <= MaxCnt);
  a_aw_limit : assert property (@(posedge clk) disable iff (reset) aw_cnt_q <= MaxCnt);
  a_base_stable : assert property (@(posedge clk) disable iff (reset)
                                   (state_q != StSwitch) |=> $stable(cur_base_q));

endmodule

// File: tb/tb_axi_remap_ctrl.sv
// Bench for axi_remap_ctrl: a gating table, directed corner sequences and
// randomized traffic, all compared against a behavioural model.
module tb_axi_remap_ctrl;
  localparam int MO = 16;
  localparam int CW = $clog2(MO + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_valid, cfg_ready, busy, err_underflow;
  logic [3:0]    cfg_base, cur_base;
  logic          s_arvalid, s_arready, m_arvalid, m_arready;
  logic          s_awvalid, s_awready, m_awvalid, m_awready;
  logic          m_rvalid, m_rready, m_rlast, m_bvalid, m_bready;
  logic [CW-1:0] ar_outst, aw_outst;

  axi_remap_ctrl #(.BASE_W(4), .RESET_BASE(4'h8), .MAX_OUTST(MO)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_base(cfg_base), .cfg_ready(cfg_ready),
    .cur_base(cur_base), .busy(busy), .err_underflow(err_underflow),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .ar_outst(ar_outst), .aw_outst(aw_outst)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit seen_ready;

  // Model: phase 0 = serving traffic, 1 = waiting for quiescence, 2 = applying base.
  int md_phase, md_base, md_pend, md_ar, md_aw;
  bit md_arh, md_awh, md_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit md_open(input int cnt, input bit hold);
    return ((md_phase == 0) && (cnt < MO)) || hold;
  endfunction

  task automatic model_reset();
    md_phase = 0; md_base = 8; md_pend = 8;
    md_ar = 0; md_aw = 0; md_arh = 0; md_awh = 0; md_err = 0;
  endtask

  task automatic check_outputs();
    bit oar, oaw;
    oar = md_open(md_ar, md_arh);
    oaw = md_open(md_aw, md_awh);
    chk("m_arvalid", m_arvalid, s_arvalid && oar);
    chk("s_arready", s_arready, m_arready && oar);
    chk("m_awvalid", m_awvalid, s_awvalid && oaw);
    chk("s_awready", s_awready, m_awready && oaw);
    chk("cfg_ready", cfg_ready, md_phase == 2);
    chk("busy", busy, md_phase != 0);
    chk("cur_base", cur_base, md_base);
    chk("err_underflow", err_underflow, md_err);
    chk("ar_outst", ar_outst, md_ar);
    chk("aw_outst", aw_outst, md_aw);
    seen_ready = cfg_ready;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit mar, maw, far, faw, dr, db, quiet;
    mar   = s_arvalid && md_open(md_ar, md_arh);
    maw   = s_awvalid && md_open(md_aw, md_awh);
    far   = mar && m_arready;
    faw   = maw && m_awready;
    dr    = m_rvalid && m_rready && m_rlast;
    db    = m_bvalid && m_bready;
    quiet = (md_ar == 0) && (md_aw == 0) && !md_arh && !md_awh;
    if (far && !dr) md_ar++;
    else if (dr && !far) begin
      if (md_ar == 0) md_err = 1; else md_ar--;
    end
    if (faw && !db) md_aw++;
    else if (db && !faw) begin
      if (md_aw == 0) md_err = 1; else md_aw--;
    end
    if (mar) md_arh = !m_arready;
    if (maw) md_awh = !m_awready;
    case (md_phase)
      0: if (cfg_valid) begin md_pend = cfg_base; md_phase = 1; end
      1: if (quiet) md_phase = 2;
      default: begin md_base = md_pend; md_phase = 0; end
    endcase
  endtask

  // Check at the falling edge, step the model at the rising edge, return at edge+1.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    cfg_valid = 0; cfg_base = 0;
    s_arvalid = 0; m_arready = 0; s_awvalid = 0; m_awready = 0;
    m_rvalid = 0; m_rready = 0; m_rlast = 0; m_bvalid = 0; m_bready = 0;
  endtask

  task automatic apply_reset();
    reset = 1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  typedef struct {
    bit sar, mar_rdy, saw, maw_rdy;
    bit e_mar, e_sar, e_maw, e_saw;
  } gate_vec_t;

  gate_vec_t gv[8];
  bit got;

  initial begin
    clear_inputs();
    reset = 1;
    model_reset();

    // Pass-through gating in RUN with empty counters (combinational).
    gv[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
    gv[1] = '{1, 0, 0, 0, 1, 0, 0, 0};
    gv[2] = '{0, 1, 0, 0, 0, 1, 0, 0};
    gv[3] = '{1, 1, 0, 0, 1, 1, 0, 0};
    gv[4] = '{0, 0, 1, 0, 0, 0, 1, 0};
    gv[5] = '{0, 0, 0, 1, 0, 0, 0, 1};
    gv[6] = '{0, 0, 1, 1, 0, 0, 1, 1};
    gv[7] = '{1, 1, 1, 1, 1, 1, 1, 1};

    apply_reset();
    #1;
    chk("reset cur_base", cur_base, 4'h8);
    chk("reset busy", busy, 0);
    chk("reset cfg_ready", cfg_ready, 0);
    chk("reset ar_outst", ar_outst, 0);
    chk("reset aw_outst", aw_outst, 0);
    chk("reset err", err_underflow, 0);

    // Inputs are removed before each rising edge, so no state changes here.
    for (int i = 0; i < 8; i++) begin
      s_arvalid = gv[i].sar; m_arready = gv[i].mar_rdy;
      s_awvalid = gv[i].saw; m_awready = gv[i].maw_rdy;
      #1;
      chk("tbl m_arvalid", m_arvalid, gv[i].e_mar);
      chk("tbl s_arready", s_arready, gv[i].e_sar);
      chk("tbl m_awvalid", m_awvalid, gv[i].e_maw);
      chk("tbl s_awready", s_awready, gv[i].e_saw);
      clear_inputs();
      @(posedge clk);
      #1;
    end

    // Same-cycle AR handshake, then retire it.
    s_arvalid = 1; m_arready = 1;
    #1;
    chk("ar pass m_arvalid", m_arvalid, 1);
    chk("ar pass s_arready", s_arready, 1);
    cycle();
    clear_inputs();
    chk("ar pass count", ar_outst, 1);
    m_rvalid = 1; m_rready = 1; m_rlast = 1;
    cycle();
    clear_inputs();

    // Three reads outstanding, then request base 9.
    s_arvalid = 1; m_arready = 1;
    repeat (3) cycle();
    s_arvalid = 0;
    cfg_valid = 1; cfg_base = 4'h9;
    cycle();
    s_arvalid = 1;
    #1;
    chk("drain busy", busy, 1);
    chk("drain ar blocked m_arvalid", m_arvalid, 0);
    chk("drain ar blocked s_arready", s_arready, 0);
    chk("drain ar_outst", ar_outst, 3);
    cycle();
    s_arvalid = 0;
    m_rvalid = 1; m_rready = 1; m_rlast = 1;
    repeat (3) cycle();
    m_rvalid = 0; m_rready = 0; m_rlast = 0;
    #1;
    chk("sw9 ready early", cfg_ready, 0);
    chk("sw9 base early", cur_base, 4'h8);
    cycle();
    chk("sw9 ready pulse", cfg_ready, 1);
    chk("sw9 base during pulse", cur_base, 4'h8);
    cycle();
    cfg_valid = 0;
    #1;
    chk("sw9 ready after", cfg_ready, 0);
    chk("sw9 base", cur_base, 4'h9);
    chk("sw9 busy", busy, 0);

    // AW stalled when the request arrives: must stay exposed until accepted.
    s_awvalid = 1; m_awready = 0; cfg_valid = 1; cfg_base = 4'h3;
    cycle();
    #1;
    chk("aw hold m_awvalid", m_awvalid, 1);
    chk("aw hold busy", busy, 1);
    cycle();
    m_awready = 1;
    cycle();
    s_awvalid = 0; m_awready = 0;
    #1;
    chk("aw hold count", aw_outst, 1);
    repeat (2) cycle();
    chk("aw wait no ready", cfg_ready, 0);
    m_bvalid = 1; m_bready = 1;
    cycle();
    m_bvalid = 0; m_bready = 0;
    got = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (cfg_ready === 1'b1) begin
        got = 1;
        cycle();
        break;
      end
      cycle();
    end
    chk("aw switch pulse seen", got, 1);
    cfg_valid = 0;
    #1;
    chk("aw switch base", cur_base, 4'h3);

    // Fill AR to the limit.
    s_arvalid = 1; m_arready = 1;
    repeat (MO) cycle();
    #1;
    chk("full ar_outst", ar_outst, MO);
    chk("full s_arready", s_arready, 0);
    chk("full m_arvalid", m_arvalid, 0);
    cycle();
    s_arvalid = 0; m_rvalid = 1; m_rready = 1; m_rlast = 1;
    cycle();
    s_arvalid = 1;
    #1;
    chk("reopen s_arready", s_arready, 1);
    cycle();
    chk("fire+rlast count", ar_outst, MO - 1);
    m_rvalid = 0; m_rready = 0; m_rlast = 0;
    cycle();
    chk("refill count", ar_outst, MO);
    chk("refill closed", s_arready, 0);
    s_arvalid = 0; m_rvalid = 1; m_rready = 1; m_rlast = 1;
    repeat (MO) cycle();
    clear_inputs();
    #1;
    chk("emptied ar", ar_outst, 0);

    // B with nothing outstanding.
    m_bvalid = 1; m_bready = 1;
    cycle();
    clear_inputs();
    #1;
    chk("uflow err", err_underflow, 1);
    chk("uflow aw_outst", aw_outst, 0);
    cycle();
    chk("uflow sticky", err_underflow, 1);

    // Reset in the middle of a drain with two reads outstanding.
    s_arvalid = 1; m_arready = 1;
    repeat (2) cycle();
    s_arvalid = 0; cfg_valid = 1; cfg_base = 4'h5;
    cycle();
    #1;
    chk("pre-reset busy", busy, 1);
    chk("pre-reset ar", ar_outst, 2);
    reset = 1;
    model_reset();
    #1;
    chk("mid reset busy", busy, 0);
    chk("mid reset ar", ar_outst, 0);
    chk("mid reset base", cur_base, 4'h8);
    chk("mid reset err", err_underflow, 0);
    clear_inputs();
    @(posedge clk);
    #1;
    reset = 0;
    repeat (6) cycle();

    // Randomized traffic; requester holds cfg_valid until it sees cfg_ready.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 799) == 0) begin
        clear_inputs();
        apply_reset();
      end
      s_arvalid = ($urandom_range(0, 2) != 0);
      m_arready = $urandom_range(0, 1);
      s_awvalid = ($urandom_range(0, 2) != 0);
      m_awready = $urandom_range(0, 1);
      m_rvalid  = ($urandom_range(0, 2) == 0);
      m_rready  = ($urandom_range(0, 3) != 0);
      m_rlast   = $urandom_range(0, 1);
      m_bvalid  = ($urandom_range(0, 2) == 0);
      m_bready  = ($urandom_range(0, 3) != 0);
      if (cfg_valid) begin
        if (seen_ready) cfg_valid = 0;
      end else if ($urandom_range(0, 29) == 0) begin
        cfg_valid = 1;
        cfg_base  = 4'($urandom_range(0, 15));
      end
      seen_ready = 0;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
